// File: rtl/alu_chk_scoreboard.sv
// alu_chk_scoreboard
//   Response checker for the serial ALU datapath. It predicts each result from a decoded
//   request and queues the prediction in an in-order FIFO. It then compares decoded
//   responses against the FIFO head and keeps saturating pass/fail/timeout statistics.
//
// Ports
//   clk, rst_n                     clock (rising edge), async active-low reset
//   in_valid, in_frame_err,
//   in_crc_err, in_op, in_a, in_b  decoded request (one-cycle pulse)
//   out_valid, out_status, out_c,
//   out_flags, out_err_flags,
//   out_parity                     decoded response (one-cycle pulse)
//   pass_cnt, fail_cnt,
//   timeout_cnt                    saturating statistics
//   mismatch                       one-cycle pulse per failed compare
//   overflow, unexpected           sticky: request dropped on full / response on empty
//   halted                         STOP_ON_FAIL tripped (exit only through reset)
//   pending                        FIFO occupancy
module alu_chk_scoreboard #(
   parameter int unsigned W            = 32,
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned CNT_W        = 16,
   parameter int unsigned TIMEOUT      = 1024,
   parameter bit          STOP_ON_FAIL = 1'b0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   input  logic                     in_frame_err,
   input  logic                     in_crc_err,
   input  logic [2:0]               in_op,
   input  logic [W-1:0]             in_a,
   input  logic [W-1:0]             in_b,
   input  logic                     out_valid,
   input  logic                     out_status,
   input  logic [W-1:0]             out_c,
   input  logic [3:0]               out_flags,
   input  logic [5:0]               out_err_flags,
   input  logic                     out_parity,
   output logic [CNT_W-1:0]         pass_cnt,
   output logic [CNT_W-1:0]         fail_cnt,
   output logic [CNT_W-1:0]         timeout_cnt,
   output logic                     mismatch,
   output logic                     overflow,
   output logic                     unexpected,
   output logic                     halted,
   output logic [$clog2(DEPTH):0]   pending
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   typedef struct packed {
      logic         status;
      logic [W-1:0] c;
      logic [3:0]   flags;
      logic [5:0]   err;
      logic         parity;
   } pred_t;

   typedef enum logic [0:0] {StRun, StHalt} state_e;

   state_e           state_q, state_d;
   pred_t            mem_q [DEPTH];
   pred_t            pred, head;
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      cnt_q, cnt_d;
   logic [TW-1:0]    wait_q, wait_d;
   logic [CNT_W-1:0] pass_q, fail_q, to_q;
   logic             mismatch_q, overflow_q, unexpected_q;

   logic             run, empty, full;
   logic             pop_cmp, to_fire, pop, push_req, push, drop, unexp;
   logic             cmp_ok, pass_now, fail_now;
   logic [W:0]       sum, diff, res;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Prediction from the decoded request
   always_comb begin
      pred = '0;
      sum  = {1'b0, in_b} + {1'b0, in_a};
      diff = {1'b0, in_b} - {1'b0, in_a};   // bit W is the borrow
      res  = '0;
      if (in_frame_err) begin
         pred.status = 1'b1;
         pred.err    = 6'b100100;
      end else if (in_crc_err) begin
         pred.status = 1'b1;
         pred.err    = 6'b010010;
      end else begin
         case (in_op)
            3'b000: res = {1'b0, in_b & in_a};
            3'b001: res = {1'b0, in_b | in_a};
            3'b100: begin
               res            = sum;
               pred.flags[2]  = (in_a[W-1] == in_b[W-1]) && (sum[W-1] != in_a[W-1]);
            end
            3'b101: begin
               res            = diff;
               pred.flags[2]  = (in_b[W-1] != in_a[W-1]) && (diff[W-1] != in_b[W-1]);
            end
            default: begin
               pred.status = 1'b1;
               pred.err    = 6'b001001;
            end
         endcase
      end
      if (pred.status) begin
         pred.flags  = '0;
         pred.parity = ^{1'b1, pred.err};
      end else begin
         pred.c        = res[W-1:0];
         pred.flags[3] = res[W];
         pred.flags[1] = (res[W-1:0] == '0);
         pred.flags[0] = res[W-1];
      end
   end

   // Compare against the FIFO head; C/flags only matter for OK, err/parity only for ERROR
   always_comb begin
      head   = mem_q[rd_ptr_q];
      cmp_ok = (out_status == head.status) &&
               (head.status ? ((out_err_flags == head.err) && (out_parity == head.parity))
                            : ((out_c == head.c) && (out_flags == head.flags)));
   end

   // Handshake decode
   always_comb begin
      run      = (state_q == StRun);
      empty    = (cnt_q == '0);
      full     = (cnt_q == (AW+1)'(DEPTH));
      pop_cmp  = run && out_valid && !empty;
      unexp    = run && out_valid && empty;
      // A response in the same cycle resolves the head, so no timeout is counted then
      to_fire  = run && !empty && !out_valid && (wait_q == TW'(TIMEOUT - 1));
      pop      = pop_cmp || to_fire;
      push_req = run && in_valid;
      push     = push_req && (!full || pop);
      drop     = push_req && full && !pop;
      pass_now = pop_cmp && cmp_ok;
      fail_now = pop_cmp && !cmp_ok;
   end

   always_comb begin
      cnt_d = cnt_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + (AW+1)'(1);
         2'b01:   cnt_d = cnt_q - (AW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
      if (!run) begin
         wait_d = wait_q;
      end else if (empty || pop) begin
         wait_d = '0;
      end else begin
         wait_d = wait_q + TW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= pred;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         cnt_q        <= '0;
         wait_q       <= '0;
         pass_q       <= '0;
         fail_q       <= '0;
         to_q         <= '0;
         mismatch_q   <= 1'b0;
         overflow_q   <= 1'b0;
         unexpected_q <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         cnt_q      <= cnt_d;
         wait_q     <= wait_d;
         mismatch_q <= fail_now;
         if (pass_now) pass_q <= sat_inc(pass_q);
         if (fail_now) fail_q <= sat_inc(fail_q);
         if (to_fire)  to_q   <= sat_inc(to_q);
         if (drop)     overflow_q   <= 1'b1;
         if (unexp)    unexpected_q <= 1'b1;
      end
   end

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StRun;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StRun:   if (STOP_ON_FAIL && (fail_now || to_fire)) state_d = StHalt;
         StHalt:  state_d = StHalt;
         default: state_d = StRun;
      endcase
   end

   // FSM: outputs
   always_comb begin
      halted = (state_q == StHalt);
   end

   assign pass_cnt    = pass_q;
   assign fail_cnt    = fail_q;
   assign timeout_cnt = to_q;
   assign mismatch    = mismatch_q;
   assign overflow    = overflow_q;
   assign unexpected  = unexpected_q;
   assign pending     = cnt_q;

endmodule

// File: tb/tb_alu_chk_scoreboard.sv
// Directed bench for alu_chk_scoreboard: a default instance, a TIMEOUT=8 instance and a
// STOP_ON_FAIL=1 instance share the same stimulus; each phase checks the relevant one.
module tb_alu_chk_scoreboard;

   localparam int unsigned W = 32;
   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b100;
   localparam logic [2:0] OP_SUB = 3'b101;
   localparam logic [2:0] OP_BAD = 3'b111;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         in_valid = 1'b0, in_frame_err = 1'b0, in_crc_err = 1'b0;
   logic [2:0]   in_op = '0;
   logic [W-1:0] in_a = '0, in_b = '0;
   logic         out_valid = 1'b0, out_status = 1'b0, out_parity = 1'b0;
   logic [W-1:0] out_c = '0;
   logic [3:0]   out_flags = '0;
   logic [5:0]   out_err_flags = '0;

   logic [15:0]  d_pass, d_fail, d_to, t_pass, t_fail, t_to, s_pass, s_fail, s_to;
   logic         d_mm, d_ovf, d_unx, d_hlt, t_mm, t_ovf, t_unx, t_hlt, s_mm, s_ovf, s_unx, s_hlt;
   logic [2:0]   d_pend, t_pend, s_pend;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   alu_chk_scoreboard u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_frame_err(in_frame_err),
      .in_crc_err(in_crc_err), .in_op(in_op), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_status(out_status), .out_c(out_c), .out_flags(out_flags),
      .out_err_flags(out_err_flags), .out_parity(out_parity),
      .pass_cnt(d_pass), .fail_cnt(d_fail), .timeout_cnt(d_to), .mismatch(d_mm),
      .overflow(d_ovf), .unexpected(d_unx), .halted(d_hlt), .pending(d_pend)
   );

   alu_chk_scoreboard #(.TIMEOUT(8)) u_dut_to (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_frame_err(in_frame_err),
      .in_crc_err(in_crc_err), .in_op(in_op), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_status(out_status), .out_c(out_c), .out_flags(out_flags),
      .out_err_flags(out_err_flags), .out_parity(out_parity),
      .pass_cnt(t_pass), .fail_cnt(t_fail), .timeout_cnt(t_to), .mismatch(t_mm),
      .overflow(t_ovf), .unexpected(t_unx), .halted(t_hlt), .pending(t_pend)
   );

   alu_chk_scoreboard #(.STOP_ON_FAIL(1'b1)) u_dut_sf (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_frame_err(in_frame_err),
      .in_crc_err(in_crc_err), .in_op(in_op), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_status(out_status), .out_c(out_c), .out_flags(out_flags),
      .out_err_flags(out_err_flags), .out_parity(out_parity),
      .pass_cnt(s_pass), .fail_cnt(s_fail), .timeout_cnt(s_to), .mismatch(s_mm),
      .overflow(s_ovf), .unexpected(s_unx), .halted(s_hlt), .pending(s_pend)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic fe, input logic ce);
      in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_frame_err = fe; in_crc_err = ce;
   endtask

   task automatic set_rsp(input logic st, input logic [W-1:0] c, input logic [3:0] fl,
                          input logic [5:0] ef, input logic par);
      out_valid = 1'b1; out_status = st; out_c = c; out_flags = fl;
      out_err_flags = ef; out_parity = par;
   endtask

   task automatic idle();
      in_valid = 1'b0; in_frame_err = 1'b0; in_crc_err = 1'b0; out_valid = 1'b0;
   endtask

   task automatic send_req(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic fe, input logic ce);
      set_req(op, a, b, fe, ce);
      tick();
      idle();
   endtask

   task automatic send_rsp(input logic st, input logic [W-1:0] c, input logic [3:0] fl,
                           input logic [5:0] ef, input logic par);
      set_rsp(st, c, fl, ef, par);
      tick();
      idle();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #2 rst_n = 1'b0;
      #1;
      check_eq("reset_outputs", 64'({d_pass, d_fail, d_to, d_mm, d_ovf, d_unx, d_hlt, d_pend}),
               64'(0));
      tick();
      rst_n = 1'b1;
      tick();

      // ADD 1 + FFFFFFFF -> C=0, carry, zero
      send_req(OP_ADD, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0);
      check_eq("pending_after_req", 64'(d_pend), 64'(1));
      send_rsp(1'b0, 32'h0, 4'b1010, 6'h0, 1'b0);
      check_eq("add_pass", 64'(d_pass), 64'(1));
      check_eq("add_no_mismatch", 64'(d_mm), 64'(0));
      check_eq("pending_after_rsp", 64'(d_pend), 64'(0));

      // SUB 0 - 1 -> FFFFFFFF with borrow and negative
      send_req(OP_SUB, 32'h1, 32'h0, 1'b0, 1'b0);
      send_rsp(1'b0, 32'hFFFF_FFFF, 4'b1001, 6'h0, 1'b0);
      check_eq("sub_pass", 64'(d_pass), 64'(2));
      send_req(OP_SUB, 32'h1, 32'h0, 1'b0, 1'b0);
      send_rsp(1'b0, 32'hFFFF_FFFF, 4'b0001, 6'h0, 1'b0);
      check_eq("sub_fail_cnt", 64'(d_fail), 64'(1));
      check_eq("sub_mismatch_pulse", 64'(d_mm), 64'(1));
      tick();
      check_eq("mismatch_cleared", 64'(d_mm), 64'(0));

      // Error predictions
      send_req(OP_ADD, 32'h5, 32'h6, 1'b0, 1'b1);
      send_rsp(1'b1, 32'h0, 4'h0, 6'b010010, 1'b1);
      check_eq("crc_err_pass", 64'(d_pass), 64'(3));
      send_req(OP_BAD, 32'h5, 32'h6, 1'b0, 1'b0);
      send_rsp(1'b1, 32'h0, 4'h0, 6'b010010, 1'b1);
      check_eq("bad_op_fail", 64'(d_fail), 64'(2));
      send_req(OP_BAD, 32'h5, 32'h6, 1'b1, 1'b1);
      send_rsp(1'b1, 32'h1234, 4'hF, 6'b100100, 1'b1);
      check_eq("frame_err_pass", 64'(d_pass), 64'(4));

      // AND and signed-overflow ADD, back-to-back request/response
      send_req(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 1'b0);
      send_rsp(1'b0, 32'hF000_F000, 4'b0001, 6'h0, 1'b0);
      check_eq("and_pass", 64'(d_pass), 64'(5));
      send_req(OP_ADD, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
      send_rsp(1'b0, 32'h8000_0000, 4'b0101, 6'h0, 1'b0);
      check_eq("add_ovf_pass", 64'(d_pass), 64'(6));
      check_eq("no_sticky_yet", 64'({d_ovf, d_unx, d_hlt}), 64'(0));

      // Fill, full-with-pop, then overflow
      do_reset();
      for (int i = 0; i < 4; i++) send_req(OP_ADD, 32'h1, 32'hFFFF_FFFF, 1'b0, 1'b0);
      check_eq("full_pending", 64'(d_pend), 64'(4));
      set_req(OP_ADD, 32'h1, 32'hFFFF_FFFF, 1'b0, 1'b0);
      set_rsp(1'b0, 32'h0, 4'b1010, 6'h0, 1'b0);
      tick();
      idle();
      check_eq("full_pop_pending", 64'(d_pend), 64'(4));
      check_eq("full_pop_no_ovf", 64'(d_ovf), 64'(0));
      check_eq("full_pop_pass", 64'(d_pass), 64'(1));
      send_req(OP_ADD, 32'h1, 32'hFFFF_FFFF, 1'b0, 1'b0);
      check_eq("overflow_set", 64'(d_ovf), 64'(1));
      check_eq("overflow_pending", 64'(d_pend), 64'(4));

      // Response on empty FIFO, same cycle as a request
      do_reset();
      check_eq("post_reset_clear", 64'({d_ovf, d_pass, d_pend}), 64'(0));
      set_req(OP_ADD, 32'h1, 32'hFFFF_FFFF, 1'b0, 1'b0);
      set_rsp(1'b0, 32'h0, 4'b1010, 6'h0, 1'b0);
      tick();
      idle();
      check_eq("unexpected_set", 64'(d_unx), 64'(1));
      check_eq("unexpected_no_count", 64'({d_pass, d_fail}), 64'(0));
      check_eq("unexpected_pending", 64'(d_pend), 64'(1));

      // Timeout on the TIMEOUT=8 instance
      do_reset();
      send_req(OP_ADD, 32'h1, 32'h2, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) tick();
      check_eq("to_not_yet_cnt", 64'(t_to), 64'(0));
      check_eq("to_not_yet_pend", 64'(t_pend), 64'(1));
      tick();
      check_eq("to_cnt", 64'(t_to), 64'(1));
      check_eq("to_pending", 64'(t_pend), 64'(0));

      // Halt on first failure
      do_reset();
      send_req(OP_SUB, 32'h1, 32'h0, 1'b0, 1'b0);
      check_eq("sf_not_halted", 64'(s_hlt), 64'(0));
      send_rsp(1'b0, 32'hFFFF_FFFF, 4'b0001, 6'h0, 1'b0);
      check_eq("sf_halted", 64'(s_hlt), 64'(1));
      check_eq("sf_fail", 64'(s_fail), 64'(1));
      send_req(OP_ADD, 32'h1, 32'hFFFF_FFFF, 1'b0, 1'b0);
      send_rsp(1'b0, 32'h0, 4'b1010, 6'h0, 1'b0);
      send_req(OP_ADD, 32'h1, 32'hFFFF_FFFF, 1'b0, 1'b0);
      check_eq("sf_frozen", 64'({s_pass, s_fail, s_pend, s_hlt}), 64'({16'd0, 16'd1, 3'd0, 1'b1}));
      check_eq("dut_live_pass", 64'(d_pass), 64'(1));
      check_eq("dut_live_pend", 64'(d_pend), 64'(1));

      // Asynchronous reset mid-stream, away from any clock edge
      #2 rst_n = 1'b0;
      #1;
      check_eq("async_rst_dut",
               64'({d_pass, d_fail, d_to, d_mm, d_ovf, d_unx, d_hlt, d_pend}), 64'(0));
      check_eq("async_rst_sf",
               64'({s_pass, s_fail, s_to, s_mm, s_ovf, s_unx, s_hlt, s_pend}), 64'(0));
      tick();
      rst_n = 1'b1;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_chk_scoreboard.md
# alu_chk_scoreboard

Synthesizable, parametrised response checker for the serial ALU datapath. It sits beside the DUT, downstream of the input and output frame deserializers. It predicts each result from the decoded request, queues predictions in an in-order FIFO, and compares them against decoded responses. It keeps saturating pass/fail/timeout statistics and supports an optional halt-on-first-failure mode.

## Interface
- `W`, 32: operand/result width (≥ 4).
- `DEPTH`, 4: prediction FIFO entries (power of two, ≥ 2).
- `CNT_W`, 16: statistics counter width.
- `TIMEOUT`, 1024: maximum cycles the head entry may wait for a response (≥ 2).
- `STOP_ON_FAIL`, 0: when 1, first mismatch or timeout halts the checker.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `in_valid` in 1: one decoded request, one-cycle pulse.
- `in_frame_err` in 1: request frame malformed (bad byte count/markers).
- `in_crc_err` in 1: request CRC4 mismatch, flagged by the deserializer.
- `in_op` in 3: opcode: AND=000, OR=001, ADD=100, SUB=101; others are invalid.
- `in_a`, `in_b` in W: operands.
- `out_valid` in 1: one decoded response, one-cycle pulse.
- `out_status` in 1: 0=OK, 1=ERROR.
- `out_c` in W: result.
- `out_flags` in 4: {carry, overflow, zero, negative}.
- `out_err_flags` in 6: {ERR_DATA, ERR_CRC, ERR_OP, copy of [5:3]}.
- `out_parity` in 1: error-frame parity.
- `pass_cnt`, `fail_cnt`, `timeout_cnt` out CNT_W: saturating counters.
- `mismatch` out 1: one-cycle pulse per failed compare.
- `overflow` out 1: sticky; a request was dropped while the FIFO was full.
- `unexpected` out 1: sticky; a response arrived with the FIFO empty.
- `halted` out 1: STOP_ON_FAIL tripped.
- `pending` out clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- **Prediction on `in_valid`.** Error priority is data > CRC > op. Exactly one error bit is set:
  - `in_frame_err`: status ERROR, err_flags = 6'b100100.
  - else `in_crc_err`: status ERROR, err_flags = 6'b010010.
  - else invalid op: status ERROR, err_flags = 6'b001001.
  - Predicted parity = ^{1'b1, err_flags}, which is 1 for any single error.
- **Valid ops.**
  - AND/OR: C = B&A or B|A; carry = 0, overflow = 0.
  - ADD: {carry, C} = B + A at W+1 bits; overflow = (A[W-1] == B[W-1]) && (C[W-1] != A[W-1]).
  - SUB: {carry, C} = B − A at W+1 bits, so carry is the borrow; overflow = (B[W-1] != A[W-1]) && (C[W-1] != B[W-1]).
  - All ops: negative = C[W-1]; zero = (C == 0).
- **Compare on `out_valid` with the FIFO non-empty.** Pop the head.
  - Pass requires status equal. If OK, C and flags must also be equal. If ERROR, err_flags and parity must be equal, and C/flags are ignored.
  - Pass increments `pass_cnt`. Fail increments `fail_cnt` and pulses `mismatch`.
- **`out_valid` with the FIFO empty**, including a same-cycle `in_valid`: set `unexpected`; no pop, no count.
- **Push with the FIFO full.**
  - Full with no pop: drop the request and set `overflow`.
  - Full with a simultaneous pop: the push is accepted and occupancy is unchanged.
- **Timeout.**
  - The wait counter clears when the FIFO is empty or on any pop, and increments otherwise.
  - When it reaches TIMEOUT: drop the head, increment `timeout_cnt`, clear the counter.
  - A timeout coinciding with `out_valid` is resolved by the compare; no timeout is counted.
- **Counters** saturate at all-ones.
- **FSM** states: RUN, HALT.
  - RUN→HALT on a fail or timeout when STOP_ON_FAIL = 1.
  - In HALT: `in_valid`/`out_valid` are ignored, counters and FIFO freeze, `halted` = 1.
  - HALT exits only through reset.

## Timing
- Reset (async, any time, including mid-transaction): FIFO empty, wait counter 0, FSM RUN. All outputs 0: counters, `mismatch`, `overflow`, `unexpected`, `halted`, `pending`.
- A prediction is written on the `in_valid` edge; `pending` updates one cycle later.
- Compare result is registered: counters, `mismatch`, and `halted` update on the edge after the `out_valid` cycle.
- A response accepted in the same cycle as its own request is not allowed; it is treated as unexpected.
- Back-to-back `in_valid`/`out_valid` on consecutive cycles are supported; throughput is 1 per cycle.

## Test plan
- Defaults; request ADD A=0x00000001, B=0xFFFFFFFF; response OK, C=0, flags=4'b1010 → `pass_cnt`=1, no `mismatch`.
- SUB A=1, B=0 answered with C=0xFFFFFFFF, flags=4'b1001 → pass. Repeat with flags=4'b0001 → `fail_cnt`=1 and a `mismatch` pulse one cycle after `out_valid`.
- `in_crc_err`=1 answered with ERROR, err_flags=6'b010010, parity=1 → pass. Op=3'b111 answered with err_flags=6'b010010 → fail.
- Five requests with no responses (DEPTH=4) → `overflow`=1, `pending`=4. Then `out_valid` on an empty FIFO after a reset → `unexpected`=1.
- TIMEOUT=8, one request with no response → `timeout_cnt`=1 after 8 cycles and `pending`=0.
- STOP_ON_FAIL=1: one bad response → `halted`=1 and later traffic leaves counters frozen. Assert `rst_n` mid-stream → all outputs 0.
